aes_key_schedule_seq: RTL and testbench
=======================================

Name: aes_key_schedule_seq

Overview:
- Iterative, one-word-per-cycle AES key schedule engine; successor to the combinational per-column inverse key-expansion cells.
- Parametrised for AES-128/192/256 via NK. Runs in forward mode (round key 0 → NR) or inverse mode (final key material → round key 0).
- Streams 128-bit round keys to the cipher/decipher datapath over a valid/ready handshake.
- A single shared SubWord unit (4 S-box instances) serves both directions.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8.
- NR, NK+6, number of rounds (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- dir  input  1  0 = forward, 1 = inverse; captured with start.
- key_in  input  32*NK  forward: cipher key w[0..NK-1]. Inverse: last NK schedule words w[4(NR+1)-NK .. 4NR+3]. Lowest-indexed word sits in the MSBs.
- busy  output  1  high from start acceptance until done.
- rk_valid  output  1  rk_data/rk_index valid.
- rk_ready  input  1  consumer accepts when rk_valid && rk_ready.
- rk_data  output  128  round key; lowest-indexed word in [127:96].
- rk_index  output  4  round number of rk_data.
- done  output  1  one-cycle pulse after the final round key is accepted.

Behaviour:
- Reset (synchronous; valid any cycle, including mid-run):
  - Outputs: busy=0, rk_valid=0, done=0, rk_data=0, rk_index=0.
  - FSM returns to IDLE; window, assembly and counters are cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on start. That edge loads the window (NK x 32 regs) from key_in and latches dir. The word counter i is set to 0 (forward) or 4(NR+1)-1 (inverse).
  - start while busy is ignored.
- Word stream: one word enters the 4-word assembly register per advancing cycle.
  - Forward order: w[0], w[1], …; inverse order: w[4NR+3] downward.
  - The first NK words come straight from the loaded window. After that, each word is computed.
- Forward step: w[i] = w[i-NK] ^ f(w[i-1]).
  - f = SubWord(RotWord(x)) ^ {Rcon[i/NK],24'h0} when i%NK==0.
  - f = SubWord(x) when NK==8 and i%NK==4.
  - Otherwise f = x.
  - The window shifts left by one word with the new word at the tail.
- Inverse step: w[i-NK] = w[i] ^ f(w[i-1]), with f chosen by index i. The window shifts right.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. The table is a case on an index; indices outside 1..10 return 00.
- Assembly and output:
  - When 4 words are assembled they transfer to the output register (rk_valid=1) if the output register is empty or is being accepted in the same cycle. Otherwise the word stream stalls and the window and counter hold.
  - Forward rk_index runs 0..NR; inverse runs NR..0. In inverse mode, words are placed so rk_data keeps ascending word order in [127:0].
- Handshake rules:
  - rk_data and rk_index are stable while rk_valid && !rk_ready.
  - rk_valid drops the cycle after acceptance unless a new key transfers in that same cycle.
- Throughput and latency:
  - 4 cycles per round key with rk_ready held high.
  - First rk_valid appears 4 cycles after the start edge.
- Completion:
  - After the last word (4(NR+1) words total), the FSM enters DRAIN.
  - On acceptance of the final round key: done=1 for one cycle, busy=0, then IDLE.
  - A start in the same cycle as done is ignored.
- Counter i spans 0..59 in 6 bits with no wrap; the step is gated off once the stream count reaches 4(NR+1).

Test Plan:
- NK=4, forward, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1 → 11 keys; rk1=a0fafe17_88542cb1_23a33939_2a6c7605, rk10=d014f9a8_c9ee2589_e13f0cc8_b6630ca6; done after rk10; total 44 word cycles.
- NK=4, inverse, key_in=d014f9a8_c9ee2589_e13f0cc8_b6630ca6 → rk_index 10,9,…,0; rk9=ac7766f3_19fadc21_28d12941_575c006e; rk0=2b7e1516_28aed2a6_abf71588_09cf4f3c.
- NK=8, forward, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 → rk2 word0=9ba35411; rk14=fe4890d1_e6188d0b_046df344_706c631e. Inverse from the last 8 words recovers that key as rk1‖rk0.
- Backpressure: NK=4 forward, rk_ready low 20 cycles on rk1 → rk_data and rk_index hold; next key follows correctly after release; sequence identical to the first test.
- reset asserted while rk_index=5 → next cycle busy=0, rk_valid=0. A fresh start then produces rk0 with correct values.
- start pulsed while busy, and pulsed in the same cycle as done → ignored; the output stream is unchanged.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key schedule: one 32-bit schedule word per cycle, forward
// (round key 0 -> NR) or inverse (final key material -> round key 0).
// Four words are packed into a 128-bit round key and handed out over a
// valid/ready handshake. A single SubWord unit is shared by both directions.
module aes_key_schedule_seq #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [32*NK-1:0]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [127:0]      rk_data,
  output logic [3:0]        rk_index,
  output logic              done
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  logic          r_dir;
  logic [31:0]   r_win [NK];
  logic [5:0]    r_i;
  logic [5:0]    r_cnt;
  logic [1:0]    r_asm_cnt;
  logic [31:0]   r_asm [4];
  logic          r_busy;
  logic          r_valid;
  logic          r_done;
  logic [127:0]  r_data;
  logic [3:0]    r_idx;

  logic [5:0]    w_fidx;
  logic [5:0]    w_fdiv;
  logic [5:0]    w_fmod;
  logic [5:0]    w_sel;
  logic [31:0]   w_base;
  logic [31:0]   w_prev;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub;
  logic [31:0]   w_f;
  logic [31:0]   w_calc;
  logic [31:0]   w_init;
  logic [31:0]   w_word;
  logic          w_first;
  logic          w_slot_free;
  logic          w_adv;
  logic          w_xfer;
  logic [1:0]    w_pos;
  logic [127:0]  w_key;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254, maps 0 to 0) then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] idx);
    case (idx)
      6'd1:    return 8'h01;
      6'd2:    return 8'h02;
      6'd3:    return 8'h04;
      6'd4:    return 8'h08;
      6'd5:    return 8'h10;
      6'd6:    return 8'h20;
      6'd7:    return 8'h40;
      6'd8:    return 8'h80;
      6'd9:    return 8'h1b;
      6'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // The f() selector is always the index of the newer word of the pair:
  // i itself going forward, i+NK when recovering w[i] in inverse mode.
  assign w_fidx = r_dir ? (r_i + 6'(NK)) : r_i;
  assign w_fdiv = w_fidx / 6'(NK);
  assign w_fmod = w_fidx % 6'(NK);

  assign w_first     = (r_cnt < 6'(NK));
  assign w_slot_free = !r_valid || rk_ready;
  assign w_adv       = (r_state == S_RUN) && (r_cnt < 6'(NW)) &&
                       ((r_asm_cnt != 2'd3) || w_slot_free);
  assign w_xfer      = w_adv && (r_asm_cnt == 2'd3);
  // Inverse words arrive highest-first, so they fill the key from the LSB end.
  assign w_pos       = r_dir ? ~r_asm_cnt : r_asm_cnt;
  assign w_sel       = r_dir ? (6'(NK - 1) - r_cnt) : r_cnt;

  // Next schedule word: straight from the loaded window, or computed via the shared SubWord
  always_comb begin
    w_base   = r_dir ? r_win[NK-1] : r_win[0];
    w_prev   = r_dir ? r_win[NK-2] : r_win[NK-1];
    w_sub_in = (w_fmod == 6'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = sub_word(w_sub_in);
    if (w_fmod == 6'd0) begin
      w_f = w_sub ^ {rcon(w_fdiv), 24'h000000};
    end else if ((NK == 8) && (w_fmod == 6'd4)) begin
      w_f = w_sub;
    end else begin
      w_f = w_prev;
    end
    w_calc = w_base ^ w_f;
    w_init = r_win[0];
    for (int k = 0; k < NK; k++) begin
      if (w_sel == 6'(k)) w_init = r_win[k];
    end
    w_word = w_first ? w_init : w_calc;
  end

  // Round key as it will look with the current word dropped into its slot
  always_comb begin
    w_key = '0;
    for (int q = 0; q < 4; q++) begin
      w_key[127-32*q -: 32] = (w_pos == 2'(q)) ? w_word : r_asm[q];
    end
  end

  // Control FSM, word window, assembly register and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_i       <= '0;
      r_cnt     <= '0;
      r_asm_cnt <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      for (int k = 0; k < NK; k++) r_win[k] <= '0;
      for (int k = 0; k < 4; k++)  r_asm[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle is spent in IDLE; a start there is deliberately dropped.
          if (start && !r_done) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_dir     <= dir;
            r_i       <= dir ? 6'(NW - 1) : 6'd0;
            r_cnt     <= '0;
            r_asm_cnt <= '0;
            for (int k = 0; k < NK; k++) r_win[k] <= key_in[32*(NK-k)-1 -: 32];
          end
        end
        S_RUN: begin
          if (w_adv && (r_cnt == 6'(NW - 1))) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_valid && rk_ready) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_adv) begin
        r_cnt          <= r_cnt + 6'd1;
        r_asm_cnt      <= r_asm_cnt + 2'd1;
        r_asm[w_pos]   <= w_word;
        if (r_dir) begin
          if (r_i != 6'd0) r_i <= r_i - 6'd1;
        end else begin
          r_i <= r_i + 6'd1;
        end
        if (!w_first) begin
          if (r_dir) begin
            for (int k = 1; k < NK; k++) r_win[k] <= r_win[k-1];
            r_win[0] <= w_calc;
          end else begin
            for (int k = 0; k < NK - 1; k++) r_win[k] <= r_win[k+1];
            r_win[NK-1] <= w_calc;
          end
        end
      end

      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_key;
        // Last word of a round key has index 4r+3 (forward) or 4r (inverse).
        r_idx   <= r_i[5:2];
      end else if (r_valid && rk_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_valid;
  assign rk_data  = r_data;
  assign rk_index = r_idx;
  assign done     = r_done;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for aes_key_schedule_seq: an AES-128 and an AES-256
// instance, directed FIPS-197 vectors, expected keys queued at issue time and
// compared by per-instance monitors on each accepted handshake.
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_a, start_a, dir_a, ready_a, busy_a, valid_a, done_a;
  logic [127:0]  key_a, data_a;
  logic [3:0]    idx_a;
  logic          reset_b, start_b, dir_b, ready_b, busy_b, valid_b, done_b;
  logic [255:0]  key_b;
  logic [127:0]  data_b;
  logic [3:0]    idx_b;

  aes_key_schedule_seq #(.NK(4)) u_a (
    .clk(clk), .reset(reset_a), .start(start_a), .dir(dir_a), .key_in(key_a),
    .busy(busy_a), .rk_valid(valid_a), .rk_ready(ready_a), .rk_data(data_a),
    .rk_index(idx_a), .done(done_a));

  aes_key_schedule_seq #(.NK(8)) u_b (
    .clk(clk), .reset(reset_b), .start(start_b), .dir(dir_b), .key_in(key_b),
    .busy(busy_b), .rk_valid(valid_b), .rk_ready(ready_b), .rk_data(data_b),
    .rk_index(idx_b), .done(done_b));

  localparam logic [127:0] K128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] RK [0:10] = '{
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'hac7766f3_19fadc21_28d12941_575c006e,
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
  localparam logic [255:0] K256 =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] K256_HI = 128'h603deb10_15ca71be_2b73aef0_857d7781;
  localparam logic [127:0] K256_LO = 128'h1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] RK14_256 = 128'hfe4890d1_e6188d0b_046df344_706c631e;
  localparam logic [127:0] RK2W0 = {32'h9ba35411, 96'h0};
  localparam logic [127:0] M_W0  = {32'hffffffff, 96'h0};
  localparam logic [127:0] M_ALL = {128{1'b1}};
  localparam logic [127:0] M_NONE = 128'h0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    logic [127:0] mask;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [127:0] cap13;

  int checks = 0;
  int errors = 0;
  int n, fv;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  task automatic chki(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic push_a(input logic [3:0] i, input logic [127:0] d, input logic [127:0] m);
    exp_t e;
    e.idx = i; e.data = d; e.mask = m;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] i, input logic [127:0] d, input logic [127:0] m);
    exp_t e;
    e.idx = i; e.data = d; e.mask = m;
    qb.push_back(e);
  endtask

  // Scoreboard monitor for the AES-128 instance
  always @(negedge clk) begin
    if (!reset_a && valid_a && ready_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra got idx %0d data %h want none", idx_a, data_a);
      end else begin
        ea = qa.pop_front();
        chki("a_idx", int'(idx_a), int'(ea.idx));
        chk("a_rk", data_a & ea.mask, ea.data & ea.mask);
      end
    end
  end

  // Scoreboard monitor for the AES-256 instance
  always @(negedge clk) begin
    if (!reset_b && valid_b && ready_b) begin
      if (!dir_b && idx_b == 4'd13) cap13 = data_b;
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra got idx %0d data %h want none", idx_b, data_b);
      end else begin
        eb = qb.pop_front();
        chki("b_idx", int'(idx_b), int'(eb.idx));
        chk("b_rk", data_b & eb.mask, eb.data & eb.mask);
      end
    end
  end

  task automatic go_a(input logic d, input logic [127:0] k);
    @(posedge clk); #1;
    start_a = 1'b1; dir_a = d; key_a = k;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic d, input logic [255:0] k);
    @(posedge clk); #1;
    start_b = 1'b1; dir_b = d; key_b = k;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_a(input int want, input string nm);
    int c;
    for (c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (valid_a && idx_a == 4'(want)) break;
    end
    if (c > 300) begin
      checks++; errors++;
      $display("FAIL %s timeout got no rk_index %0d want it within 300 cycles", nm, want);
    end
  endtask

  task automatic wait_a_done(output int cyc, output int first_v);
    int c;
    first_v = 0;
    for (c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (valid_a && first_v == 0) first_v = c;
      if (done_a) break;
    end
    cyc = c;
    if (c > 300) begin
      checks++; errors++;
      $display("FAIL a_done timeout got no done want done within 300 cycles");
    end
  endtask

  task automatic wait_b_done(output int cyc, output int first_v);
    int c;
    first_v = 0;
    for (c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (valid_b && first_v == 0) first_v = c;
      if (done_b) break;
    end
    cyc = c;
    if (c > 300) begin
      checks++; errors++;
      $display("FAIL b_done timeout got no done want done within 300 cycles");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish before 400us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_a = 1'b1; start_a = 1'b0; dir_a = 1'b0; key_a = '0; ready_a = 1'b1;
    reset_b = 1'b1; start_b = 1'b0; dir_b = 1'b0; key_b = '0; ready_b = 1'b1;
    cap13 = '0;
    repeat (3) @(posedge clk);
    #1;
    chki("a_rst_busy", int'(busy_a), 0);
    chki("a_rst_valid", int'(valid_a), 0);
    chki("a_rst_done", int'(done_a), 0);
    chk("a_rst_data", data_a, 128'h0);
    chki("a_rst_idx", int'(idx_a), 0);
    chki("b_rst_busy", int'(busy_b), 0);
    chki("b_rst_valid", int'(valid_b), 0);
    reset_a = 1'b0; reset_b = 1'b0;

    // AES-128 forward, ready held high
    for (int r = 0; r <= 10; r++) push_a(4'(r), RK[r], M_ALL);
    go_a(1'b0, K128);
    wait_a_done(n, fv);
    chki("a_fwd_first_valid_cycle", fv - 1, 4);
    chki("a_fwd_done_cycle", n - 1, 45);
    chki("a_done_busy", int'(busy_a), 0);
    @(negedge clk);
    chki("a_done_one_cycle", int'(done_a), 0);
    chki("a_fwd_queue", qa.size(), 0);

    // AES-128 inverse from the final round key
    for (int r = 10; r >= 0; r--) push_a(4'(r), RK[r], M_ALL);
    go_a(1'b1, RK[10]);
    wait_a_done(n, fv);
    chki("a_inv_first_valid_cycle", fv - 1, 4);
    chki("a_inv_queue", qa.size(), 0);

    // Backpressure on round key 1
    for (int r = 0; r <= 10; r++) push_a(4'(r), RK[r], M_ALL);
    go_a(1'b0, K128);
    wait_a(0, "a_bp_rk0");
    @(posedge clk); #1;
    ready_a = 1'b0;
    wait_a(1, "a_bp_rk1");
    repeat (20) begin
      @(negedge clk);
      chki("a_bp_valid", int'(valid_a), 1);
      chk("a_bp_data", data_a, RK[1]);
      chki("a_bp_idx", int'(idx_a), 1);
    end
    @(posedge clk); #1;
    ready_a = 1'b1;
    wait_a_done(n, fv);
    chki("a_bp_queue", qa.size(), 0);

    // Reset in the middle of a run, then a fresh run
    for (int r = 0; r <= 5; r++) push_a(4'(r), RK[r], M_ALL);
    go_a(1'b0, K128);
    wait_a(5, "a_rst_rk5");
    @(posedge clk); #1;
    reset_a = 1'b1;
    @(posedge clk); #1;
    chki("a_midrst_busy", int'(busy_a), 0);
    chki("a_midrst_valid", int'(valid_a), 0);
    chki("a_midrst_idx", int'(idx_a), 0);
    chk("a_midrst_data", data_a, 128'h0);
    reset_a = 1'b0;
    chki("a_midrst_queue", qa.size(), 0);
    for (int r = 0; r <= 10; r++) push_a(4'(r), RK[r], M_ALL);
    go_a(1'b0, K128);
    wait_a_done(n, fv);
    chki("a_after_rst_first_valid_cycle", fv - 1, 4);
    chki("a_after_rst_queue", qa.size(), 0);

    // start while busy and in the done cycle must be ignored
    for (int r = 0; r <= 10; r++) push_a(4'(r), RK[r], M_ALL);
    go_a(1'b0, K128);
    repeat (10) @(posedge clk);
    #1;
    start_a = 1'b1; dir_a = 1'b1; key_a = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_a(10, "a_ign_rk10");
    @(posedge clk); #1;
    chki("a_ign_done_high", int'(done_a), 1);
    start_a = 1'b1; dir_a = 1'b0; key_a = K128;
    @(posedge clk); #1;
    start_a = 1'b0;
    chki("a_ign_busy_after_done", int'(busy_a), 0);
    repeat (8) @(negedge clk);
    chki("a_ign_valid_idle", int'(valid_a), 0);
    chki("a_ign_busy_idle", int'(busy_a), 0);
    chki("a_ign_queue", qa.size(), 0);

    // AES-256 forward
    push_b(4'd0, K256_HI, M_ALL);
    push_b(4'd1, K256_LO, M_ALL);
    push_b(4'd2, RK2W0, M_W0);
    for (int r = 3; r <= 13; r++) push_b(4'(r), 128'h0, M_NONE);
    push_b(4'd14, RK14_256, M_ALL);
    go_b(1'b0, K256);
    wait_b_done(n, fv);
    chki("b_fwd_done_cycle", n - 1, 61);
    chki("b_fwd_queue", qb.size(), 0);

    // AES-256 inverse from the last eight words recovers the cipher key
    push_b(4'd14, RK14_256, M_ALL);
    for (int r = 13; r >= 3; r--) push_b(4'(r), 128'h0, M_NONE);
    push_b(4'd2, RK2W0, M_W0);
    push_b(4'd1, K256_LO, M_ALL);
    push_b(4'd0, K256_HI, M_ALL);
    go_b(1'b1, {cap13, RK14_256});
    wait_b_done(n, fv);
    chki("b_inv_queue", qb.size(), 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
